// File: rtl/id_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_decode_ctrl: RV32I decode-stage slot, imm-select and ID/EX reg.    |
// | Optional macro ILLEGAL_TRAP_EN: hold illegal opcodes in a TRAP state. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module id_decode_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  input  logic                   flush,
  input  logic                   haz_memread,
  input  logic [4:0]             haz_rd,
  output logic [31:0]            ext_in,
  output logic [2:0]             imm_src,
  input  logic [31:0]            ext_imm,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_imm,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic [7:0]             ex_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   illegal
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  localparam logic [2:0] c_imm_i    = 3'b000;
  localparam logic [2:0] c_imm_s    = 3'b001;
  localparam logic [2:0] c_imm_b    = 3'b010;
  localparam logic [2:0] c_imm_j    = 3'b011;
  localparam logic [2:0] c_imm_u    = 3'b100;
  localparam logic [2:0] c_imm_none = 3'b111;

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_stall = 2'd1;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [1:0] c_st_trap  = 2'd2;
`endif

  localparam logic [STALL_CNT_W-1:0] c_cnt_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic                   id_valid_q, id_valid_d;
  logic [31:0]            id_instr_q, id_instr_d;
  logic [31:0]            id_pc_q, id_pc_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [31:0]            ex_pc_q, ex_pc_d;
  logic [31:0]            ex_imm_q, ex_imm_d;
  logic [4:0]             ex_rs1_q, ex_rs1_d;
  logic [4:0]             ex_rs2_q, ex_rs2_d;
  logic [4:0]             ex_rd_q, ex_rd_d;
  logic [7:0]             ex_ctrl_q, ex_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   illegal_q, illegal_d;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1, w_rs2;
  logic [7:0] w_ctrl;
  logic       w_legal, w_uses_rs1, w_uses_rs2, w_imm_none;
  logic       w_haz, w_dn_free, w_run, w_trap_hit, w_adv, w_stall_go;

  assign w_opcode = id_instr_q[6:0];
  assign w_rs1    = id_instr_q[19:15];
  assign w_rs2    = id_instr_q[24:20];
  assign ext_in   = id_instr_q;

  // ex_ctrl bit order: {reg_write, mem_read, mem_write, alu_src, branch, jump, pc_rel, is_sys}
  always_comb begin
    imm_src    = c_imm_none;
    w_ctrl     = 8'h00;
    w_legal    = 1'b1;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      c_op_load:   begin imm_src = c_imm_i; w_ctrl = 8'b1101_0000; end
      c_op_opimm:  begin imm_src = c_imm_i; w_ctrl = 8'b1001_0000; end
      c_op_jalr:   begin imm_src = c_imm_i; w_ctrl = 8'b1001_0100; end
      c_op_system: begin imm_src = c_imm_i; w_ctrl = 8'b0000_0001; end
      c_op_store:  begin imm_src = c_imm_s; w_ctrl = 8'b0011_0000; w_uses_rs2 = 1'b1; end
      c_op_branch: begin imm_src = c_imm_b; w_ctrl = 8'b0000_1010; w_uses_rs2 = 1'b1; end
      c_op_jal:    begin imm_src = c_imm_j; w_ctrl = 8'b1000_0110; w_uses_rs1 = 1'b0; end
      c_op_lui:    begin imm_src = c_imm_u; w_ctrl = 8'b1001_0000; w_uses_rs1 = 1'b0; end
      c_op_auipc:  begin imm_src = c_imm_u; w_ctrl = 8'b1001_0010; w_uses_rs1 = 1'b0; end
      c_op_op:     begin imm_src = c_imm_none; w_ctrl = 8'b1000_0000; w_uses_rs2 = 1'b1; end
      default:     w_legal = 1'b0;
    endcase
  end

  // R-type and illegal opcodes have no immediate; the extender output is ignored
  assign w_imm_none = (w_opcode == c_op_op) | ~w_legal;

  always_comb begin
    w_haz = id_valid_q & haz_memread & (haz_rd != 5'd0) &
            ((w_uses_rs1 & (haz_rd == w_rs1)) | (w_uses_rs2 & (haz_rd == w_rs2)));
    w_dn_free = ~ex_valid_q | ex_ready;
    w_run     = (state_q == c_st_run);
`ifdef ILLEGAL_TRAP_EN
    w_trap_hit = w_run & id_valid_q & ~w_legal;
`else
    w_trap_hit = 1'b0;
`endif
    w_adv      = id_valid_q & ~w_haz & w_dn_free & w_run & ~w_trap_hit;
    w_stall_go = w_run & w_haz & w_dn_free & ~w_trap_hit;
    if_ready   = ~flush & w_run & (~id_valid_q | w_adv);
  end

  always_comb begin
    state_d     = state_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_imm_d    = ex_imm_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_rd_d     = ex_rd_q;
    ex_ctrl_d   = ex_ctrl_q;
    stall_cnt_d = stall_cnt_q;
    illegal_d   = illegal_q;

    if (flush) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
      state_d    = c_st_run;
      illegal_d  = 1'b0;
    end else begin
      case (state_q)
        c_st_run: begin
          if (w_trap_hit) begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = c_st_trap;
`endif
            illegal_d = 1'b1;
          end else if (w_stall_go) begin
            state_d = c_st_stall;
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + c_cnt_one;
          end
        end
        c_st_stall: state_d = c_st_run;
`ifdef ILLEGAL_TRAP_EN
        c_st_trap:  state_d = c_st_trap;
`endif
        default:    state_d = c_st_run;
      endcase

      if (w_adv) begin
        ex_valid_d = 1'b1;
        ex_pc_d    = id_pc_q;
        ex_imm_d   = w_imm_none ? 32'h0 : ext_imm;
        ex_rs1_d   = w_rs1;
        ex_rs2_d   = w_rs2;
        ex_rd_d    = id_instr_q[11:7];
        ex_ctrl_d  = w_ctrl;
      end else if (ex_ready) begin
        ex_valid_d = 1'b0;
      end

      if (if_valid & if_ready) begin
        id_valid_d = 1'b1;
        id_instr_d = if_instr;
        id_pc_d    = if_pc;
      end else if (w_adv) begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= c_st_run;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= 32'h0;
      ex_imm_q    <= 32'h0;
      ex_rs1_q    <= 5'h0;
      ex_rs2_q    <= 5'h0;
      ex_rd_q     <= 5'h0;
      ex_ctrl_q   <= 8'h0;
      stall_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_imm_q    <= ex_imm_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_pc     = ex_pc_q;
  assign ex_imm    = ex_imm_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;
  assign ex_rd     = ex_rd_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_cnt_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule
`default_nettype wire
